// File: rtl/sync_ram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_ram_pkg : shared widths, depth and clear-sequencer state type   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sync_ram_pkg;

   localparam int c_DATA_W  = 8;
   localparam int c_KERN_AW = 4;
   localparam int c_PIX_AW  = 6;
   localparam int c_DEPTH   = 1 << (c_KERN_AW + c_PIX_AW);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clrState_t;

endpackage
`default_nettype wire

// File: rtl/sync_ram_clear_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_ram_clear_seq : post-reset zero-fill sequencer, one word/cycle  |
// | Used only when SYNC_RAM_INIT_CLEAR_EN is defined.    Rev 1.0         |
// +----------------------------------------------------------------------+
import sync_ram_pkg::*;

module sync_ram_clear_seq #(
   parameter int ADDR_W = c_KERN_AW + c_PIX_AW
) (
   input  logic              Clk,
   input  logic              Rst,
   output logic              clrWe,
   output logic [ADDR_W-1:0] clrAddr,
   output logic              Ready
);

   clrState_t         r_state;
   clrState_t         w_nextState;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] w_nextAddr;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state <= CLEAR;
         r_addr  <= '0;
      end else begin
         r_state <= w_nextState;
         r_addr  <= w_nextAddr;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_nextAddr  = r_addr;
      clrWe       = 1'b0;
      case (r_state)
         CLEAR: begin
            clrWe = 1'b1;
            // Last word written this cycle: hand the array back next cycle.
            if (&r_addr) begin
               w_nextState = IDLE;
            end else begin
               w_nextAddr = r_addr + ADDR_W'(1);
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   assign clrAddr = r_addr;
   assign Ready   = (r_state == IDLE);

endmodule
`default_nettype wire

// File: rtl/sync_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_ram : single-port kernel/pixel addressed RAM, registered read   |
// | Optional zero-fill after reset: SYNC_RAM_INIT_CLEAR_EN.  Rev 1.0     |
// +----------------------------------------------------------------------+
import sync_ram_pkg::*;

module sync_ram #(
   parameter int DATA_W  = c_DATA_W,
   parameter int KERN_AW = c_KERN_AW,
   parameter int PIX_AW  = c_PIX_AW
) (
   input  logic                Clk,
   input  logic                Rst,
   input  logic                CS,
   input  logic                WE,
   input  logic                RD,
   input  logic [KERN_AW-1:0]  kernAddr,
   input  logic [PIX_AW-1:0]   pixAddr,
   input  logic [DATA_W-1:0]   dataIn,
   output logic [DATA_W-1:0]   dataOut,
   output logic                Ready
);

   localparam int c_ADDR_W = KERN_AW + PIX_AW;
   localparam int c_DEPTH_L = 1 << c_ADDR_W;

   logic [DATA_W-1:0]   r_mem [0:c_DEPTH_L-1];
   logic [DATA_W-1:0]   r_dataOut;
   logic [c_ADDR_W-1:0] w_addr;
   logic                w_ready;
   logic                w_access;
   logic                w_usrWr;
   logic                w_usrRd;
   logic                w_memWe;
   logic [c_ADDR_W-1:0] w_memAddr;
   logic [DATA_W-1:0]   w_memData;

   assign w_addr   = {kernAddr, pixAddr};
   // Reset outranks any access presented on the same edge.
   assign w_access = CS & w_ready & ~Rst;
   assign w_usrWr  = w_access & WE;
   assign w_usrRd  = w_access & RD & ~WE;

`ifdef SYNC_RAM_INIT_CLEAR_EN
   logic                w_clrWe;
   logic [c_ADDR_W-1:0] w_clrAddr;

   sync_ram_clear_seq #(
      .ADDR_W (c_ADDR_W)
   ) u_clearSeq (
      .Clk     (Clk),
      .Rst     (Rst),
      .clrWe   (w_clrWe),
      .clrAddr (w_clrAddr),
      .Ready   (w_ready)
   );

   assign w_memWe   = w_usrWr | (w_clrWe & ~Rst);
   assign w_memAddr = w_clrWe ? w_clrAddr : w_addr;
   assign w_memData = w_clrWe ? '0 : dataIn;
`else
   assign w_ready   = 1'b1;
   assign w_memWe   = w_usrWr;
   assign w_memAddr = w_addr;
   assign w_memData = dataIn;
`endif

   always_ff @(posedge Clk) begin
      if (w_memWe) begin
         r_mem[w_memAddr] <= w_memData;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_dataOut <= '0;
      end else if (w_usrRd) begin
         r_dataOut <= r_mem[w_addr];
      end
   end

   assign dataOut = r_dataOut;
   assign Ready   = w_ready;

endmodule
`default_nettype wire

// File: tb/tb_sync_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sync_ram : directed + random bench with a behavioural RAM model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_sync_ram;

   localparam int DW    = 8;
   localparam int KA    = 4;
   localparam int PA    = 6;
   localparam int DEPTH = 1 << (KA + PA);

   logic          Clk = 1'b0;
   logic          Rst = 1'b1;
   logic          CS = 1'b0, WE = 1'b0, RD = 1'b0;
   logic [KA-1:0] kernAddr = '0;
   logic [PA-1:0] pixAddr = '0;
   logic [DW-1:0] dataIn = '0;
   logic [DW-1:0] dataOut;
   logic          Ready;

   sync_ram dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .CS       (CS),
      .WE       (WE),
      .RD       (RD),
      .kernAddr (kernAddr),
      .pixAddr  (pixAddr),
      .dataIn   (dataIn),
      .dataOut  (dataOut),
      .Ready    (Ready)
   );

   always #5 Clk = ~Clk;

   int nAssert = 0;
   int nFail   = 0;

   // Behavioural model: a plain word array plus the expected output state.
   logic [DW-1:0] mdl [DEPTH];
   bit            known [DEPTH];
   logic [DW-1:0] expData  = '0;
   bit            expKnown = 1'b0;
   bit            expReady = 1'b0;
   int            clrLeft  = 0;
   bit            chkOn    = 1'b0;

   always @(negedge Clk) begin
      if (chkOn) begin
         nAssert++;
         if (Ready !== expReady) begin
            nFail++;
            $display("FAIL ready: got %b want %b at %0t", Ready, expReady, $time);
         end
         if (expKnown) begin
            nAssert++;
            if (dataOut !== expData) begin
               nFail++;
               $display("FAIL dataOut: got %h want %h at %0t", dataOut, expData, $time);
            end
         end
      end
   end

   task automatic lit(input string name, input int act, input int exp);
      nAssert++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit rst, input bit cs, input bit we, input bit rd,
                       input int k, input int p, input logic [DW-1:0] d);
      int a;
      Rst = rst; CS = cs; WE = we; RD = rd;
      kernAddr = k[KA-1:0]; pixAddr = p[PA-1:0]; dataIn = d;
      a = k * (1 << PA) + p;
      @(posedge Clk);
      if (rst) begin
         expData  = '0;
         expKnown = 1'b1;
         chkOn    = 1'b1;
`ifdef SYNC_RAM_INIT_CLEAR_EN
         clrLeft  = DEPTH;
         expReady = 1'b0;
`else
         expReady = 1'b1;
`endif
      end else if (clrLeft > 0) begin
         mdl[DEPTH - clrLeft]   = '0;
         known[DEPTH - clrLeft] = 1'b1;
         clrLeft--;
         expReady = (clrLeft == 0);
      end else if (cs && we) begin
         mdl[a]   = d;
         known[a] = 1'b1;
      end else if (cs && rd) begin
         expData  = mdl[a];
         expKnown = known[a];
      end
      @(negedge Clk);
   endtask

   task automatic wr(input int k, input int p, input logic [DW-1:0] d);
      step(1'b0, 1'b1, 1'b1, 1'b0, k, p, d);
   endtask

   task automatic rd(input int k, input int p);
      step(1'b0, 1'b1, 1'b0, 1'b1, k, p, '0);
   endtask

   // Reset, then (with the clear sequencer) try writes while it runs.
   task automatic doReset();
      int n;
      step(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 8'hEE);
      lit("rst_dataOut", int'(dataOut), 0);
`ifdef SYNC_RAM_INIT_CLEAR_EN
      n = 0;
      while (Ready !== 1'b1 && n < 2000) begin
         step(1'b0, 1'b1, 1'b1, 1'b0, 0, n % 64, 8'hEE);
         n++;
      end
      lit("clear_cycles", n, 1024);
`else
      n = 0;
      lit("rst_ready", int'(Ready), 1);
`endif
   endtask

   initial begin
      logic [DW-1:0] vals [5];
      vals[0] = 8'h00; vals[1] = 8'h01; vals[2] = 8'h10; vals[3] = 8'h06; vals[4] = 8'h12;
      for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

      doReset();

      for (int i = 0; i < 5; i++) wr(0, i, vals[i]);
      for (int i = 0; i < 5; i++) begin
         rd(0, i);
         lit("read_back", int'(dataOut), int'(vals[i]));
      end

      wr(1, 0, 8'hAA);
      rd(0, 0);
      lit("no_alias_k0", int'(dataOut), 8'h00);
      rd(1, 0);
      lit("no_alias_k1", int'(dataOut), 8'hAA);

      step(1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 8'h55);
      lit("cs0_hold", int'(dataOut), 8'hAA);
      rd(0, 1);
      lit("cs0_nowrite", int'(dataOut), 8'h01);

      rd(0, 2);
      lit("pre_rst_read", int'(dataOut), 8'h10);
      doReset();
      rd(0, 2);
`ifdef SYNC_RAM_INIT_CLEAR_EN
      lit("post_rst_read", int'(dataOut), 8'h00);
`else
      lit("post_rst_read", int'(dataOut), 8'h10);
`endif

      step(1'b0, 1'b1, 1'b1, 1'b1, 0, 3, 8'h77);
`ifdef SYNC_RAM_INIT_CLEAR_EN
      lit("we_rd_hold", int'(dataOut), 8'h00);
`else
      lit("we_rd_hold", int'(dataOut), 8'h10);
`endif
      rd(0, 3);
      lit("we_rd_write", int'(dataOut), 8'h77);

      // Top corner of the address space.
      wr(15, 63, 8'h5A);
      rd(15, 63);
      lit("top_addr", int'(dataOut), 8'h5A);

      for (int a = 0; a < DEPTH; a++) wr(a / 64, a % 64, DW'($urandom));

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(499) == 0) begin
            doReset();
         end else begin
            step(1'b0, ($urandom_range(3) != 0), $urandom_range(1) == 1,
                 $urandom_range(1) == 1, $urandom_range(15), $urandom_range(63),
                 DW'($urandom));
         end
      end

      for (int a = 0; a < DEPTH; a++) rd(a / 64, a % 64);

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sync_ram.md
SYNC_RAM -- requirements
Module: sync_ram

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits.
REQ-002 Parameter KERN_AW, default 4, kernel address width (16 kernels).
REQ-003 Parameter PIX_AW, default 6, pixel address width (64 pixels per kernel).
REQ-004 Clk  input  1  clock; all state changes on the rising edge only.
REQ-005 Rst  input  1  reset; synchronous, active-high.
REQ-006 CS  input  1  chip select; no access without it.
REQ-007 WE  input  1  write enable.
REQ-008 RD  input  1  read enable.
REQ-009 kernAddr  input  KERN_AW  kernel index, upper address field.
REQ-010 pixAddr  input  PIX_AW  pixel index, lower address field.
REQ-011 dataIn  input  DATA_W  write data.
REQ-012 dataOut  output  DATA_W  registered read data.
REQ-013 Ready  output  1  high when accesses are accepted.

Function
REQ-014 Storage SHALL be 2^(KERN_AW+PIX_AW) words of DATA_W bits (1024 x 8 by default); linear address = {kernAddr, pixAddr}.
REQ-015 Write: rising edge with CS=1, WE=1, Ready=1, Rst=0 SHALL store dataIn at the linear address.
REQ-016 Read: rising edge with CS=1, RD=1, WE=0, Ready=1, Rst=0 SHALL load dataOut with the word at the linear address; latency one cycle.
REQ-017 CS=1 with WE=1 and RD=1 SHALL perform the write only; dataOut holds.
REQ-018 dataOut SHALL hold its last value in every cycle without a read, including CS=0 and Ready=0.
REQ-019 Inputs with CS=0 SHALL have no effect on storage or on dataOut.
REQ-020 Addresses SHALL be fully decoded; no aliasing between kernels and no wrap beyond the field widths.

Reset
REQ-021 Rst=1 at a rising edge SHALL set dataOut to 0 and take priority over any access presented in that cycle.
REQ-022 Storage contents SHALL NOT be altered by reset unless SYNC_RAM_INIT_CLEAR_EN is defined.
REQ-023 Without SYNC_RAM_INIT_CLEAR_EN, Ready SHALL be 1 in every cycle after the reset edge.

Configuration
REQ-024 Macro SYNC_RAM_INIT_CLEAR_EN SHALL enable the post-reset clear sequencer.
REQ-025 With the macro defined, the sequencer SHALL have two states, IDLE and CLEAR; reset enters CLEAR with the clear address at 0.
REQ-026 In CLEAR, the sequencer SHALL write 0 to one address per cycle in ascending order, hold Ready=0, and ignore CS, WE and RD.
REQ-027 After writing the last address (1023 by default), the sequencer SHALL enter IDLE and drive Ready=1 from the next cycle; total clear time is 2^(KERN_AW+PIX_AW) cycles.
REQ-028 Reset asserted during CLEAR SHALL restart the clear sequence from address 0.
REQ-029 Without the macro, the sequencer SHALL not exist, and Ready SHALL behave per REQ-023.

Structure
REQ-030 Package sync_ram_pkg SHALL hold the default widths, the depth constant, and the sequencer state enum.
REQ-031 The clear sequencer SHALL be sub-module sync_ram_clear_seq, instantiated only under SYNC_RAM_INIT_CLEAR_EN; the storage array SHALL remain in sync_ram.

Verification
REQ-032 Write (kern 0, pix 0..4) = 0x00, 0x01, 0x10, 0x06, 0x12, then read the same addresses in order -> dataOut = 0x00, 0x01, 0x10, 0x06, 0x12, each one cycle after its read edge.
REQ-033 Write 0xAA to (kern 1, pix 0) after REQ-032 -> a read of (kern 0, pix 0) still returns 0x00, and a read of (kern 1, pix 0) returns 0xAA.
REQ-034 CS=0, WE=1, dataIn=0x55 at (0,1), then read (0,1) -> 0x01; dataOut unchanged during the CS=0 cycle.
REQ-035 Read (0,2) and assert Rst on the following edge -> dataOut = 0x10 then 0x00; a subsequent read of (0,2) returns 0x10 without the macro.
REQ-036 WE=1 and RD=1 with dataIn=0x77 at (0,3) -> dataOut unchanged that cycle; a later read of (0,3) returns 0x77.
REQ-037 With SYNC_RAM_INIT_CLEAR_EN: reset -> Ready=0 for 1024 cycles, then Ready=1; every address reads 0x00; a write attempted during CLEAR is ignored.
